// File: rtl/cpu_fetch_pkg.sv
// Shared types for the fetch stage: FSM state encoding and a queue entry layout.
package cpu_fetch_pkg;
  localparam int PC_W_DEF = 30;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_W_DEF-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_queue_chk.sv
// Protocol and credit invariants of the prefetch queue.
module instr_prefetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             run_i,
  input logic             rvalid_i,
  input logic [CNT_W-1:0] live_i,
  input logic [CNT_W:0]   used_i,
  input logic [CNT_W-1:0] outst_i,
  input logic [CNT_W-1:0] tag_count_i,
  input logic             grant_i,
  input logic             tag_full_i,
  input logic             tag_empty_i,
  input logic             q_push_i,
  input logic             q_full_i
);
  a_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    rvalid_i |-> (live_i != {CNT_W{1'b0}}));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    used_i <= (CNT_W+1)'(DEPTH));
  a_tag_tracks_outst: assert property (@(posedge clk) disable iff (!rst_n)
    run_i |-> (tag_count_i == outst_i));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    grant_i |-> !tag_full_i);
  a_tag_available: assert property (@(posedge clk) disable iff (!rst_n)
    q_push_i |-> !tag_empty_i);
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    q_push_i |-> !q_full_i);
endmodule

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head data is read straight from storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s, do_pop_s;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/instr_prefetch_queue.sv
// Credit-limited sequential instruction prefetcher; redirect flushes the queue and
// drains stale in-flight responses before fetching resumes at the new address.
module instr_prefetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  input  logic            out_ready
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = 32 + PC_W;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic [CNT_W-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [CNT_W-1:0] live_s, q_count_s, tag_count_s;
  logic [CNT_W:0]   used_s, credit_s;
  logic            run_s, grant_s, rsp_s, q_push_s, q_pop_s;
  logic            q_empty_s, q_full_s, tag_empty_s, tag_full_s;
  logic [EW-1:0]   q_rdata_s;
  logic [PC_W-1:0] tag_rdata_s;

  assign run_s   = (state_q == RUN);
  assign grant_s = req_q & imem_gnt;
  assign live_s  = run_s ? outst_q : discard_q;
  // A response with nothing in flight is a protocol error and is dropped.
  assign rsp_s    = imem_rvalid & (live_s != {CNT_W{1'b0}});
  assign q_push_s = run_s & rsp_s;
  assign q_pop_s  = ~q_empty_s & out_ready & ~redirect;
  assign used_s   = {1'b0, q_count_s} + {1'b0, outst_q};
  // Pops this cycle are deliberately not credited until the following cycle.
  assign credit_s = used_s + (CNT_W+1)'(grant_s);

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc_q;
  assign out_valid = ~q_empty_s;
  assign out_instr = q_rdata_s[PC_W +: 32];
  assign out_pc    = q_rdata_s[PC_W-1:0];

  // Next-state logic: redirect overrides everything, FLUSH only drains stale responses
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    req_d      = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      outst_d    = {CNT_W{1'b0}};
      discard_d  = live_s + CNT_W'(grant_s) - CNT_W'(rsp_s);
      state_d    = (discard_d != {CNT_W{1'b0}}) ? FLUSH : RUN;
    end else if (run_s) begin
      fetch_pc_d = grant_s ? (fetch_pc_q + PC_W'(1)) : fetch_pc_q;
      outst_d    = outst_q + CNT_W'(grant_s) - CNT_W'(rsp_s);
      req_d      = (credit_s < (CNT_W+1)'(DEPTH));
    end else begin
      if (rsp_s) begin
        discard_d = discard_q - CNT_W'(1);
        state_d   = (discard_q == CNT_W'(1)) ? RUN : FLUSH;
      end else begin
        discard_d = discard_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      outst_q    <= {CNT_W{1'b0}};
      discard_q  <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (q_push_s),
    .wdata_i ({imem_rdata, tag_rdata_s}),
    .pop_i   (q_pop_s),
    .rdata_o (q_rdata_s),
    .full_o  (q_full_s),
    .empty_o (q_empty_s),
    .count_o (q_count_s)
  );

  sync_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (grant_s),
    .wdata_i (fetch_pc_q),
    .pop_i   (q_push_s),
    .rdata_o (tag_rdata_s),
    .full_o  (tag_full_s),
    .empty_o (tag_empty_s),
    .count_o (tag_count_s)
  );

  instr_prefetch_queue_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run_s),
    .rvalid_i    (imem_rvalid),
    .live_i      (live_s),
    .used_i      (used_s),
    .outst_i     (outst_q),
    .tag_count_i (tag_count_s),
    .grant_i     (grant_s),
    .tag_full_i  (tag_full_s),
    .tag_empty_i (tag_empty_s),
    .q_push_i    (q_push_s),
    .q_full_i    (q_full_s)
  );
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench: in-order memory model with fixed latency, pops logged per clock edge.
module tb_instr_prefetch_queue;
  logic        clk, rst_n, redirect;
  logic [29:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [29:0] out_pc;

  typedef struct { logic [29:0] addr; int due; } rsp_t;
  rsp_t        rq[$];
  logic [29:0] got_pc[$];
  logic [31:0] got_instr[$];
  int n_tests, n_fail, edge_n, n_grants, n_resp, n_pops, lat, max_used;
  bit gnt_en;

  instr_prefetch_queue #(.DEPTH(4), .PC_W(30), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [29:0] pc);
    return {pc, 2'b01} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Log the pop of the coming edge, then drive memory inputs for the edge after it.
  task automatic tick();
    int used;
    if (rst_n && out_valid && out_ready && !redirect) begin
      got_pc.push_back(out_pc);
      got_instr.push_back(out_instr);
      n_pops++;
    end
    used = rq.size() + n_resp - n_pops;
    if (used > max_used) max_used = used;
    @(negedge clk);
    edge_n++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (rq.size() > 0 && rq[0].due <= edge_n + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(rq[0].addr);
      void'(rq.pop_front());
      n_resp++;
    end
    imem_gnt = gnt_en;
    if (imem_req && imem_gnt) begin
      rq.push_back('{addr: imem_addr, due: edge_n + 1 + lat});
      n_grants++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 30'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
    gnt_en = 1'b0; lat = 1;
    rq.delete(); got_pc.delete(); got_instr.delete();
    n_grants = 0; n_resp = 0; n_pops = 0; max_used = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, out_valid, 1'b1);
  endtask

  initial begin
    int gaps, bad;
    n_tests = 0; n_fail = 0;

    // Reset values, then back-to-back streaming with 1-cycle memory
    do_reset();
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_addr", imem_addr, 30'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 30'h0);
    gnt_en = 1'b1; lat = 1; out_ready = 1'b1;
    tick(); tick();
    check("t1_valid_c2", out_valid, 1'b0);
    gaps = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!out_valid) gaps++;
    end
    check("t1_gaps", gaps, 0);
    check("t1_count", got_pc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (got_pc.size() > i) begin
        check("t1_pc", got_pc[i], 30'(i));
        check("t1_instr", got_instr[i], instr_of(30'(i)));
      end
    end

    // Credit limit with a stalled consumer, then refill one request per pop
    do_reset();
    gnt_en = 1'b1; lat = 1; out_ready = 1'b0;
    repeat (12) tick();
    check("t2_grants", n_grants, 4);
    check("t2_req_low", imem_req, 1'b0);
    check("t2_head_pc", out_pc, 30'h0);
    out_ready = 1'b1;
    repeat (16) tick();
    check("t2_max_credit", max_used, 4);
    check("t2_enough", got_pc.size() >= 8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (got_pc.size() > i) check("t2_pc", got_pc[i], 30'(i));
    end

    // Request held stable while grant is withheld
    do_reset();
    gnt_en = 1'b0; lat = 1; out_ready = 1'b1;
    bad = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) gnt_en = 1'b1;
      tick();
      if (!imem_req || imem_addr !== 30'h0) bad++;
    end
    check("t3_hold", bad, 0);
    tick();
    check("t3_addr_adv", imem_addr, 30'h1);

    // Redirect coinciding with a third grant: three stale responses dropped
    do_reset();
    gnt_en = 1'b1; lat = 5; out_ready = 1'b1;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 30'h100;
    tick();
    redirect = 1'b0;
    bad = 0;
    if (imem_req || out_valid) bad++;
    for (int i = 5; i <= 9; i++) begin
      tick();
      if (imem_req || out_valid) bad++;
    end
    check("t4_flush_quiet", bad, 0);
    tick();
    check("t4_req_resume", imem_req, 1'b1);
    check("t4_resume_addr", imem_addr, 30'h100);
    wait_valid("t4_wait_valid");
    check("t4_first_pc", out_pc, 30'h100);
    check("t4_first_instr", out_instr, instr_of(30'h100));
    check("t4_no_stale", got_pc.size(), 0);

    // Redirect together with a pop while three entries are queued
    do_reset();
    gnt_en = 1'b1; lat = 1; out_ready = 1'b0;
    tick(); tick(); tick();
    gnt_en = 1'b0;
    tick(); tick();
    check("t5_valid_before", out_valid, 1'b1);
    check("t5_head_before", out_pc, 30'h0);
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 30'h200;
    tick();
    redirect = 1'b0;
    check("t5_flushed", out_valid, 1'b0);
    check("t5_no_pop", got_pc.size(), 0);
    check("t5_req_off", imem_req, 1'b0);
    check("t5_addr", imem_addr, 30'h200);
    gnt_en = 1'b1;
    wait_valid("t5_wait_valid");
    check("t5_first_pc", out_pc, 30'h200);

    // Fetch address wraps past the top of the word space
    do_reset();
    gnt_en = 1'b1; lat = 1; out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 30'h3FFF_FFFF;
    tick();
    redirect = 1'b0;
    tick();
    check("t6_req", imem_req, 1'b1);
    check("t6_addr_top", imem_addr, 30'h3FFF_FFFF);
    tick();
    check("t6_addr_wrap", imem_addr, 30'h0);
    repeat (8) tick();
    check("t6_count", got_pc.size() >= 3, 1'b1);
    if (got_pc.size() >= 3) begin
      check("t6_pc0", got_pc[0], 30'h3FFF_FFFF);
      check("t6_pc1", got_pc[1], 30'h0);
      check("t6_pc2", got_pc[2], 30'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Decoupled fetch stage between a variable-latency instruction memory and the CPU's decode path. It issues sequential word-address requests and buffers up to DEPTH returned instructions with their PCs. It hands them downstream over a valid/ready interface. A redirect from the branch/jump logic flushes the queue, restarts fetch at a new word address and discards stale in-flight responses.

Parameters:
DEPTH, 4, queue entries and maximum outstanding-plus-buffered credit (power of 2, >=2)
PC_W, 30, word-address width (byte address = {pc, 2'b00})
RESET_PC, 0, first fetch word address after reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
redirect  in  1  flush and restart fetch (branch/jump taken)
redirect_pc  in  PC_W  new fetch word address, sampled when redirect=1
imem_req  out  1  request valid to instruction memory
imem_addr  out  PC_W  requested word address
imem_gnt  in  1  request accepted this cycle (req&gnt = handshake)
imem_rvalid  in  1  response valid, in request order, >=1 cycle after its gnt
imem_rdata  in  32  response instruction word
out_valid  out  1  queue head valid
out_instr  out  32  head instruction
out_pc  out  PC_W  head word address
out_ready  in  1  downstream accepts head (out_valid&out_ready = pop)

Behaviour:
- Reset (async assert, sync release): state=RUN, fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0; imem_req=0, out_valid=0, imem_addr=RESET_PC, out_instr=0, out_pc=0.
- Credit: credit_used = entries + outstanding. imem_req=1 in RUN when credit_used<DEPTH. Never exceeds DEPTH. A pop in the same cycle does not free credit until the next cycle.
- imem_req/imem_addr are registered. Once raised, they hold stable until gnt, unless redirect.
- Grant: req&gnt -> outstanding+1, fetch_pc+1 (wraps modulo 2^PC_W). Each request tags the PC into a DEPTH-deep tag FIFO.
- Response in RUN: rvalid -> push {rdata, tag} into queue, outstanding-1. Visible on out_* the next cycle; there is no combinational bypass, so minimum rvalid-to-out_valid latency is 1.
- rvalid with outstanding=0 is a protocol error. It is ignored and flagged by an assertion.
- Pop: out_valid&out_ready removes the head. Push and pop in the same cycle are both honoured, including when the queue is full (rvalid cannot arrive when full due to credit).
- Redirect, highest priority, any state:
  - Queue and tag FIFO are cleared.
  - out_valid=0 next cycle; any pop in the redirect cycle is void.
  - fetch_pc=redirect_pc.
  - imem_req=0 next cycle.
  - discard = outstanding, plus 1 if req&gnt occurs this cycle, minus 1 if rvalid occurs this cycle.
  - state=FLUSH if the resulting discard>0, else RUN.
- FLUSH: imem_req=0. Each rvalid drops its data and decrements discard. At discard reaching 0, state=RUN and requests resume the following cycle.
- Redirect during FLUSH recomputes discard from the live count and keeps only the newest redirect_pc.
- States: RUN, FLUSH (2-state FSM; IDLE is not needed since fetch starts at reset release).

Decomposition:
- Shared package cpu_fetch_pkg: PC_W default, fetch_state_t {RUN, FLUSH}, fetch_entry_t {instr[31:0], pc[PC_W-1:0]}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count). Instantiated twice: once for the instruction queue and once for the PC tag FIFO.

Test Plan:
- Reset, gnt=1 always, rvalid 1 cycle after gnt, out_ready=1 -> addrs 0,1,2,... issued back-to-back; out_pc sequence 0,1,2 with out_valid from cycle 3 after reset release, no gaps.
- out_ready=0, zero-wait memory, DEPTH=4 -> exactly 4 grants then imem_req=0. Raise out_ready -> one new req issued per pop, never more than 4 in flight+buffered.
- gnt held low 5 cycles -> imem_req=1 and imem_addr=0 stable all 5 cycles; grant on cycle 6 -> addr advances to 1.
- 2 outstanding, redirect to 0x100 in the same cycle as a third gnt -> discard=3, next 3 rvalids dropped, first out_pc after flush=0x100, out_valid=0 throughout.
- Redirect and out_valid&out_ready in the same cycle, queue holding 3 -> queue empty next cycle, no entry delivered, fetch resumes at redirect_pc.
- fetch_pc=0x3FFFFFFF granted -> next imem_addr=0x0; out_pc wraps identically.
